// File: rtl/mpu_fetch.sv
// MPU fetch/decode: reads a 6-byte window at pc, decodes one variable-length instruction, issues it to execute.
// Latency: an instruction at pc is presented (ins_valid) on the clock edge after pc takes that value.
// Backpressure: ins_* hold while ins_valid && !ins_ready; a new fetch happens only when the output slot is free.
//
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   en                     run enable (low: no new fetch, held instruction may still transfer)
//   mem_addr / mem_data    read address (= pc) and the little-endian 48-bit byte window returned
//   ins_*                  decoded instruction, valid/ready handshake towards execute
//   jmp_en / jmp_addr      redirect from execute; flushes the held instruction
//   fault / fault_pc       sticky fault on illegal opcode or out-of-range fetch
module mpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MEM_SIZE = 128
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    output logic [15:0] mem_addr,
    input  logic [47:0] mem_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_pc,
    output logic [3:0]  ins_op,
    output logic [1:0]  ins_sz,
    output logic [2:0]  ins_len,
    output logic [39:0] ins_operands,
    input  logic        jmp_en,
    input  logic [15:0] jmp_addr,
    output logic        fault,
    output logic [15:0] fault_pc
);

    localparam logic [3:0]  MPU_OP_LOAD = 4'h1;
    localparam logic [3:0]  MPU_OP_MASK = 4'h2;
    localparam logic [3:0]  MPU_OP_INT  = 4'h3;
    localparam logic [3:0]  MPU_OP_JMP  = 4'h4;
    localparam logic [16:0] MEM_LIMIT   = 17'(MEM_SIZE);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t        state, state_next;
    logic [15:0]   pc;

    logic [3:0]    dec_op;
    logic [1:0]    dec_sz;
    logic [2:0]    dec_len;
    logic          dec_legal;
    logic [39:0]   dec_operands;
    logic [16:0]   end_addr;
    logic          in_bounds;
    logic          fetch_ok;
    logic          slot_free;
    logic          fetch_go;

    // byte0[3:2] carry no meaning for any opcode
    logic          unused_ok;
    assign unused_ok = &{1'b0, mem_data[3:2]};

    assign mem_addr = pc;
    assign dec_op   = mem_data[7:4];
    assign dec_sz   = mem_data[1:0];

    always_comb begin
        dec_len   = 3'd0;
        dec_legal = 1'b0;
        case (dec_op)
            MPU_OP_LOAD: begin
                case (dec_sz)
                    2'd0:    begin dec_len = 3'd3; dec_legal = 1'b1; end
                    2'd1:    begin dec_len = 3'd4; dec_legal = 1'b1; end
                    2'd2:    begin dec_len = 3'd6; dec_legal = 1'b1; end
                    default: begin dec_len = 3'd0; dec_legal = 1'b0; end
                endcase
            end
            MPU_OP_MASK: begin dec_len = 3'd5; dec_legal = 1'b1; end
            MPU_OP_INT:  begin dec_len = 3'd2; dec_legal = 1'b1; end
            MPU_OP_JMP:  begin dec_len = 3'd2; dec_legal = 1'b1; end
            default:     begin dec_len = 3'd0; dec_legal = 1'b0; end
        endcase
    end

    // Keep only the operand bytes that belong to this instruction; the rest of
    // the window is the next instruction and must read as zero.
    always_comb begin
        dec_operands = '0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < (dec_len - 3'd1)) begin
                dec_operands[i*8 +: 8] = mem_data[8 + i*8 +: 8];
            end
        end
    end

    // 17-bit end address so a fetch near 16'hffff cannot wrap into range
    assign end_addr  = {1'b0, pc} + {14'd0, dec_len};
    assign in_bounds = (end_addr <= MEM_LIMIT);
    assign fetch_ok  = dec_legal && in_bounds;
    assign slot_free = !ins_valid || ins_ready;
    assign fetch_go  = (state == ST_RUN) && en && slot_free && !jmp_en;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_RUN && fetch_go && !fetch_ok) begin
            state_next = ST_FAULT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pc           <= RESET_PC;
            ins_valid    <= 1'b0;
            ins_pc       <= '0;
            ins_op       <= '0;
            ins_sz       <= '0;
            ins_len      <= '0;
            ins_operands <= '0;
            fault        <= 1'b0;
            fault_pc     <= '0;
        end else begin
            if (ins_valid && ins_ready) begin
                ins_valid <= 1'b0;
            end
            if (state == ST_RUN) begin
                if (jmp_en) begin
                    pc        <= jmp_addr;
                    ins_valid <= 1'b0;
                end else if (fetch_go) begin
                    if (fetch_ok) begin
                        ins_valid    <= 1'b1;
                        ins_pc       <= pc;
                        ins_op       <= dec_op;
                        ins_sz       <= dec_sz;
                        ins_len      <= dec_len;
                        ins_operands <= dec_operands;
                        pc           <= pc + {13'd0, dec_len};
                    end else begin
                        fault     <= 1'b1;
                        fault_pc  <= pc;
                        ins_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
